tx_link_sched: RTL and testbench

Transmit link scheduler that sits directly in front of the PHY transmit path and drives its 32-bit data/valid input on the `clk_f` domain. After reset it sequences link training by emitting a fixed burst of training words. It then shares the transmit lane pair between two packet sources (A and B) with packet-granular round-robin arbitration. A retrain request returns the link to training without cutting a packet in half.

---
 rtl/tx_link_sched.sv | 124 ++++++++++++
 tb/tb_tx_link_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_link_sched.sv
// Transmit link scheduler: training burst after reset/retrain, then packet-granular
// round-robin sharing of the PHY transmit lane between sources A and B.
//
// state | meaning
// TRAIN | emitting TRAIN_WORDS copies of TS_WORD, sources held off
// IDLE  | output idle; retrain check, then arbitration between A and B
// PKT_A | forwarding source A until its last word (bubbles allowed)
// PKT_B | forwarding source B until its last word (bubbles allowed)
module tx_link_sched #(
    parameter int          TRAIN_WORDS = 16,
    parameter logic [31:0] TS_WORD     = 32'hBCBCBCBC
) (
    input  logic        clk_f,
    input  logic        reset,
    input  logic        retrain,
    input  logic [31:0] a_data,
    input  logic        a_valid,
    input  logic        a_last,
    output logic        a_ready,
    input  logic [31:0] b_data,
    input  logic        b_valid,
    input  logic        b_last,
    output logic        b_ready,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        link_up,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        TRAIN = 2'd0,
        IDLE  = 2'd1,
        PKT_A = 2'd2,
        PKT_B = 2'd3
    } state_t;

    localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_WORDS - 1);

    state_t     state;
    logic [7:0] train_cnt;
    logic       rr_last;       // 1: B owned the most recent packet
    logic       retrain_pend;

    assign a_ready = (state == PKT_A);
    assign b_ready = (state == PKT_B);

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state        <= TRAIN;
            train_cnt    <= 8'd0;
            data_out     <= 32'd0;
            valid_out    <= 1'b0;
            link_up      <= 1'b0;
            grant        <= 2'b00;
            rr_last      <= 1'b1;
            retrain_pend <= 1'b0;
        end else begin
            case (state)
                TRAIN: begin
                    data_out  <= TS_WORD;
                    valid_out <= 1'b1;
                    if (train_cnt == TRAIN_LAST) begin
                        state     <= IDLE;
                        train_cnt <= 8'd0;
                    end else begin
                        train_cnt <= train_cnt + 8'd1;
                    end
                end
                IDLE: begin
                    data_out  <= 32'd0;
                    valid_out <= 1'b0;
                    grant     <= 2'b00;
                    if (retrain || retrain_pend) begin
                        state        <= TRAIN;
                        link_up      <= 1'b0;
                        retrain_pend <= 1'b0;
                    end else begin
                        // link_up rises on the same edge that first drops valid after the burst
                        link_up <= 1'b1;
                        if (a_valid && (!b_valid || rr_last)) begin
                            state <= PKT_A;
                            grant <= 2'b01;
                        end else if (b_valid) begin
                            state <= PKT_B;
                            grant <= 2'b10;
                        end
                    end
                end
                PKT_A: begin
                    if (retrain) retrain_pend <= 1'b1;
                    if (a_valid) begin
                        data_out  <= a_data;
                        valid_out <= 1'b1;
                        if (a_last) begin
                            state   <= IDLE;
                            rr_last <= 1'b0;
                            grant   <= 2'b00;
                        end
                    end else begin
                        data_out  <= 32'd0;
                        valid_out <= 1'b0;
                    end
                end
                PKT_B: begin
                    if (retrain) retrain_pend <= 1'b1;
                    if (b_valid) begin
                        data_out  <= b_data;
                        valid_out <= 1'b1;
                        if (b_last) begin
                            state   <= IDLE;
                            rr_last <= 1'b1;
                            grant   <= 2'b00;
                        end
                    end else begin
                        data_out  <= 32'd0;
                        valid_out <= 1'b0;
                    end
                end
                default: state <= TRAIN;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_link_sched.sv
// Randomized scoreboard bench for tx_link_sched: packet-level round-robin model feeds an
// expected-word queue; a monitor pops and compares every valid output word.
module tb_tx_link_sched;

    localparam logic [31:0] TS = 32'hBCBCBCBC;
    localparam int          TW = 16;

    logic        clk_f = 1'b0;
    logic        reset = 1'b1;
    logic        retrain = 1'b0;
    logic [31:0] a_data, b_data, data_out;
    logic        a_valid, a_last, a_ready, b_valid, b_last, b_ready;
    logic        valid_out, link_up;
    logic [1:0]  grant;

    always #5 clk_f = ~clk_f;

    tx_link_sched #(.TRAIN_WORDS(TW), .TS_WORD(TS)) dut (
        .clk_f(clk_f), .reset(reset), .retrain(retrain),
        .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .data_out(data_out), .valid_out(valid_out), .link_up(link_up), .grant(grant)
    );

    typedef struct {logic [31:0] d; logic l;} word_t;
    typedef struct {logic [31:0] d; logic [1:0] g; logic lk; logic l; int gap;} exp_t;

    word_t a_q[$], b_q[$], gen_a[$], gen_b[$];
    exp_t  exp_q[$];
    int    n_pass = 0, n_chk = 0;
    int    bubble_pct = 0;
    logic  m_rr_b = 1'b1;   // model: B owned the last packet

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    task automatic push_train(input int first_gap);
        exp_t e;
        for (int i = 0; i < TW; i++) begin
            e.d = TS; e.g = 2'b00; e.lk = 1'b0; e.l = 1'b0;
            e.gap = (i == 0) ? first_gap : 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic gen_pkt(input bit to_a, input int len);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.d = $urandom; w.l = (i == len - 1);
            if (to_a) gen_a.push_back(w); else gen_b.push_back(w);
        end
    endtask

    // Hand the generated packets to the sources and predict the output stream.
    task automatic load_and_model();
        word_t w;
        exp_t  e;
        bit    pick_a, first;
        a_q = gen_a;
        b_q = gen_b;
        while (gen_a.size() != 0 || gen_b.size() != 0) begin
            pick_a = (gen_a.size() != 0) && (gen_b.size() == 0 || m_rr_b);
            first = 1'b1;
            do begin
                w = pick_a ? gen_a.pop_front() : gen_b.pop_front();
                e.d = w.d; e.l = w.l; e.lk = 1'b1;
                e.g = w.l ? 2'b00 : (pick_a ? 2'b01 : 2'b10);
                e.gap = first ? -1 : ((bubble_pct == 0) ? 0 : -1);
                exp_q.push_back(e);
                first = 1'b0;
            end while (!w.l);
            m_rr_b = !pick_a;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || a_q.size() != 0 || b_q.size() != 0 || link_up !== 1'b1)
               && n < budget) begin
            @(negedge clk_f);
            n++;
        end
        chk(name, n < budget, 1'b1);
    endtask

    initial begin : drv_a
        logic acc;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        forever begin
            @(negedge clk_f);
            if (a_q.size() == 0 || (a_ready && int'($urandom_range(99)) < bubble_pct)) begin
                a_valid = 1'b0; a_data = '0; a_last = 1'b0;
            end else begin
                a_valid = 1'b1; a_data = a_q[0].d; a_last = a_q[0].l;
            end
            acc = a_valid && a_ready;
            @(posedge clk_f);
            if (acc && !reset && a_q.size() != 0) void'(a_q.pop_front());
        end
    end

    initial begin : drv_b
        logic acc;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        forever begin
            @(negedge clk_f);
            if (b_q.size() == 0 || (b_ready && int'($urandom_range(99)) < bubble_pct)) begin
                b_valid = 1'b0; b_data = '0; b_last = 1'b0;
            end else begin
                b_valid = 1'b1; b_data = b_q[0].d; b_last = b_q[0].l;
            end
            acc = b_valid && b_ready;
            @(posedge clk_f);
            if (acc && !reset && b_q.size() != 0) void'(b_q.pop_front());
        end
    end

    initial begin : monitor
        int   idle;
        logic prev_last, prev_link;
        exp_t e;
        idle = 0; prev_last = 1'b0; prev_link = 1'b0;
        forever begin
            @(negedge clk_f);
            if (prev_last) chk("pkt_gap", valid_out, 1'b0);
            if (link_up === 1'b0) chk("ready_in_train", {a_ready, b_ready}, 2'b00);
            if (a_ready === 1'b1) chk("ready_onehot", b_ready, 1'b0);
            if (link_up === 1'b1 && prev_link === 1'b0)
                chk("train_done", {valid_out, exp_q.size() == 0}, 2'b01);
            prev_last = 1'b0;
            if (valid_out === 1'b1) begin
                chk("word_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("word", {data_out, grant, link_up}, {e.d, e.g, e.lk});
                    if (e.gap >= 0) chk("gap", idle, e.gap);
                    prev_last = e.l;
                end
                idle = 0;
            end else begin
                idle++;
            end
            prev_link = link_up;
        end
    end

    initial begin : main
        int    n;
        word_t w;
        exp_t  e;

        repeat (3) @(posedge clk_f);
        @(negedge clk_f);
        chk("reset_vals", {data_out, valid_out, link_up, grant, a_ready, b_ready}, 64'd0);
        push_train(-1);
        reset = 1'b0;
        wait_done("train_after_reset", 100);

        // single source, 4 fixed words
        @(posedge clk_f); #1;
        bubble_pct = 0;
        for (int k = 1; k <= 4; k++) begin
            w.d = 32'h11111111 * k; w.l = (k == 4);
            gen_a.push_back(w);
        end
        load_and_model();
        wait_done("single_source", 100);

        // contention rounds with random lengths and mid-packet bubbles
        bubble_pct = 25;
        for (int r = 0; r < 4; r++) begin
            @(posedge clk_f); #1;
            for (int p = 0; p < 3; p++) begin
                gen_pkt(1'b1, int'($urandom_range(1, 4)));
                gen_pkt(1'b0, int'($urandom_range(1, 4)));
            end
            load_and_model();
            wait_done("contention", 400);
        end

        // retrain pulse on the 2nd word of a 5-word A packet
        @(posedge clk_f); #1;
        bubble_pct = 0;
        gen_pkt(1'b1, 5);
        load_and_model();
        push_train(1);
        n = 0;
        while (!(a_ready === 1'b1 && a_q.size() == 4) && n < 100) begin
            @(negedge clk_f);
            n++;
        end
        chk("retrain_sync", n < 100, 1'b1);
        retrain = 1'b1;
        @(negedge clk_f);
        retrain = 1'b0;
        wait_done("retrain_mid_pkt", 200);

        // reset while B is mid-packet: two words out, third abandoned
        @(posedge clk_f); #1;
        gen_pkt(1'b0, 6);
        for (int i = 0; i < 2; i++) begin
            e.d = gen_b[i].d; e.g = 2'b10; e.lk = 1'b1; e.l = 1'b0;
            e.gap = (i == 0) ? -1 : 0;
            exp_q.push_back(e);
        end
        b_q = gen_b;
        gen_b.delete();
        n = 0;
        while (!(b_ready === 1'b1 && b_q.size() == 4) && n < 100) begin
            @(negedge clk_f);
            n++;
        end
        chk("reset_sync", n < 100, 1'b1);
        reset = 1'b1;
        a_q.delete();
        b_q.delete();
        m_rr_b = 1'b1;
        @(negedge clk_f);
        chk("reset_mid_vals", {data_out, valid_out, link_up, grant, a_ready, b_ready}, 64'd0);
        chk("reset_mid_words", exp_q.size(), 0);
        push_train(-1);
        reset = 1'b0;
        wait_done("train_after_reset_mid", 100);

        // first tie after reset goes to A
        @(posedge clk_f); #1;
        gen_pkt(1'b0, 2);
        gen_pkt(1'b1, 2);
        load_and_model();
        wait_done("tie_after_reset", 100);

        repeat (2) @(negedge clk_f);
        chk("leftover_words", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
